// File: rtl/seg7_mmio.sv
// seg7_mmio: memory-mapped 8-digit multiplexed hex display driver (DATA/CTRL registers).
// Optional leading-zero blanking is compiled in when SEG7_LZB_EN is defined.
module seg7_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_4000,
  parameter int unsigned SCAN_CNT  = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iAddr,
  input  logic [31:0] iData,
  input  logic        MEM_W,
  input  logic        MEM_R,
  output logic [31:0] oData,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_sel
);

  localparam int unsigned   DW        = $clog2(SCAN_CNT);
  localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_CNT - 1);

  logic [31:0]   data_q, data_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [2:0]    digit_q, digit_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    seg_q, seg_d;
  logic [7:0]    sel_q, sel_d;

  logic       hit, wr_data, wr_ctrl, rd_hit, dwell_wrap, blank;
  logic [3:0] nib;
  logic [7:0] hex;
  logic       unused_addr;

  assign unused_addr = ^iAddr[1:0];

  assign hit     = (iAddr[31:3] == BASE_ADDR[31:3]);
  assign wr_data = MEM_W && hit && !iAddr[2];
  assign wr_ctrl = MEM_W && hit &&  iAddr[2];
  assign rd_hit  = MEM_R && hit;

  always_comb begin
    data_d = wr_data ? iData : data_q;
`ifdef SEG7_LZB_EN
    ctrl_d = wr_ctrl ? iData[1:0] : ctrl_q;
`else
    ctrl_d = wr_ctrl ? {1'b0, iData[0]} : ctrl_q;
`endif
    // Read mux uses pre-write register values, so a same-cycle write/read returns old data.
    rdata_d = '0;
    if (rd_hit) rdata_d = iAddr[2] ? {30'b0, ctrl_q} : data_q;
  end

  assign dwell_wrap = (dwell_q == DWELL_MAX);
  assign dwell_d    = dwell_wrap ? '0 : dwell_q + 1'b1;
  assign digit_d    = dwell_wrap ? digit_q + 3'd1 : digit_q;

  assign nib = data_q[{digit_q, 2'b00} +: 4];

  always_comb begin
    hex = 8'hFF;
    case (nib)
      4'h0: hex = 8'hC0;
      4'h1: hex = 8'hF9;
      4'h2: hex = 8'hA4;
      4'h3: hex = 8'hB0;
      4'h4: hex = 8'h99;
      4'h5: hex = 8'h92;
      4'h6: hex = 8'h82;
      4'h7: hex = 8'hF8;
      4'h8: hex = 8'h80;
      4'h9: hex = 8'h90;
      4'hA: hex = 8'h88;
      4'hB: hex = 8'h83;
      4'hC: hex = 8'hC6;
      4'hD: hex = 8'hA1;
      4'hE: hex = 8'h86;
      4'hF: hex = 8'h8E;
      default: hex = 8'hFF;
    endcase
  end

`ifdef SEG7_LZB_EN
  logic [2:0] top_nz;
  always_comb begin
    top_nz = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (data_q[4*i +: 4] != 4'h0) top_nz = 3'(i);
    // Digit 0 can never exceed top_nz, so an all-zero value still shows a single 0.
    blank = ctrl_q[1] && (digit_q > top_nz);
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    sel_d = '1;
    seg_d = '1;
    if (ctrl_q[0]) begin
      sel_d = ~(8'h01 << digit_q);
      seg_d = blank ? '1 : hex;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      ctrl_q  <= '0;
      dwell_q <= '0;
      digit_q <= '0;
      rdata_q <= '0;
      seg_q   <= '1;
      sel_q   <= '1;
    end else begin
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      dwell_q <= dwell_d;
      digit_q <= digit_d;
      rdata_q <= rdata_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
    end
  end

  assign oData = rdata_q;
  assign o_seg = seg_q;
  assign o_sel = sel_q;

endmodule

// File: doc/seg7_mmio.md
SEG7_MMIO -- requirements
Module: seg7_mmio

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h1001_4000, giving the word address of the DATA register; the CTRL register is at BASE_ADDR+4.
REQ-002 The block SHALL have parameter SCAN_CNT, default 50000, giving the clocks each digit is held (minimum 2).
REQ-003 clk  input  1  system clock (the CPU-side divided clock); the only clock.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 iAddr  input  32  CPU data-bus byte address.
REQ-006 iData  input  32  CPU write data.
REQ-007 MEM_W  input  1  write strobe, one cycle per write.
REQ-008 MEM_R  input  1  read strobe.
REQ-009 oData  output  32  registered read data.
REQ-010 o_seg  output  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}.
REQ-011 o_sel  output  8  digit selects, active-low one-hot.

Function
REQ-012 Decode: hit when iAddr[31:3]==BASE_ADDR[31:3]; iAddr[2]=0 selects DATA, 1 selects CTRL; iAddr[1:0] ignored; non-hit accesses SHALL be ignored.
REQ-013 DATA (32 bits) SHALL load iData on the clk edge where MEM_W and DATA hit.
REQ-014 CTRL SHALL load iData[1:0] on a CTRL hit write; bit0 = display enable; bit1 = leading-zero blank (see Configuration); bits 31:2 read 0.
REQ-015 Read latency: oData SHALL present the addressed register one clock after a MEM_R hit, otherwise 32'h0.
REQ-016 Simultaneous MEM_W and MEM_R to the same register: oData SHALL return the pre-write value.
REQ-017 Dwell counter SHALL count 0..SCAN_CNT-1 and wrap; on wrap, digit index (3 bits) SHALL increment, 7 wrapping to 0.
REQ-018 Digit k SHALL show nibble DATA[4k+3:4k]; o_sel = ~(8'b1 << k).
REQ-019 Hex decode, dp always off: 0->C0, 1->F9, 2->A4, 3->B0, 4->99, 5->92, 6->82, 7->F8, 8->80, 9->90, A->88, b->83, C->C6, d->A1, E->86, F->8E.
REQ-020 o_seg and o_sel SHALL be registered; they change one clock after a digit-index change or a DATA write, never glitching between digits.
REQ-021 Enable=0: o_sel=8'hFF, o_seg=8'hFF; counters keep running.
REQ-022 A DATA write mid-dwell SHALL NOT restart the scan.

Reset
REQ-023 While rst=0: DATA=0, CTRL=0, dwell=0, digit index=0, oData=0, o_sel=8'hFF, o_seg=8'hFF.
REQ-024 On rst release, the scan SHALL start at digit 0 with a full dwell; reset asserted mid-scan or mid-read SHALL abort immediately with no pending effects.

Configuration
REQ-025 Macro SEG7_LZB_EN: when defined, CTRL bit1 is writable and, when set, digits above the highest non-zero nibble SHALL be blanked (o_sel still driven, o_seg=8'hFF); digit 0 is never blanked (DATA=0 shows a single "0").
REQ-026 Without SEG7_LZB_EN, CTRL bit1 SHALL read 0, writes to it SHALL be ignored, and all eight digits SHALL always display.

Verification (SCAN_CNT=4)
REQ-027 Reset then idle 64 clocks -> o_sel=FF, o_seg=FF, oData=0 throughout.
REQ-028 Write CTRL=1, DATA=32'h1234_ABCD -> o_sel cycles FE,FD,...,7F, 4 clocks each; o_seg A1,C6,83,88,99,B0,A4,F9.
REQ-029 Write DATA=32'hDEAD_BEEF, then MEM_R at BASE_ADDR and BASE_ADDR+4 -> oData=DEADBEEF, then 00000001, each one clock after its strobe; MEM_R at BASE_ADDR+8 -> oData=0.
REQ-030 Same-cycle write/read of DATA (old 5, new 7) -> oData=5; next read -> 7.
REQ-031 SEG7_LZB_EN, CTRL=3, DATA=32'h0000_0050 -> digits 0,1 show C0,92; digits 2..7 show o_seg=FF; DATA=0 -> only digit 0 shows C0.
REQ-032 Drop rst mid-dwell on digit 5 -> outputs FF within the same cycle; after release the scan restarts at digit 0 with DATA=0, display disabled.
